// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_pkg
// Brief    : Shared types and constants for the multiply/divide unit.
//            MULDIV_RADIX4_EN selects radix-4 Booth (half the MUL iterations).
// Revision : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

  localparam int DEFAULT_WIDTH = 32;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MUL  = 3'd1,
    DIV  = 3'd2,
    FIX  = 3'd3,
    DZ   = 3'd4,
    DONE = 3'd5
  } state_e;

  // Booth iterations needed for a given operand width.
  function automatic int mul_iters(input int width);
`ifdef MULDIV_RADIX4_EN
    return width / 2;
`else
    return width;
`endif
  endfunction

  // Non-restoring division retires one quotient bit per iteration.
  function automatic int div_iters(input int width);
    return width;
  endfunction

  localparam int MUL_ITERS = mul_iters(DEFAULT_WIDTH);
  localparam int DIV_ITERS = div_iters(DEFAULT_WIDTH);

endpackage
`default_nettype wire

// File: rtl/mul_div_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : mul_div_unit_if
// Brief    : Control-unit handshake and operand/result bus of the mul/div unit.
// Revision : 1.0 - initial release
// ============================================================================
interface mul_div_unit_if #(
  parameter int WIDTH = muldiv_pkg::DEFAULT_WIDTH
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, operand_a, operand_b,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, operand_a, operand_b,
    output busy, done, div_zero, hi, lo
  );
endinterface
`default_nettype wire

// File: rtl/mul_div_unit_div_step.sv
`default_nettype none
// ============================================================================
// Module   : div_step
// Brief    : One combinational non-restoring division iteration.
//            Partial remainder carries two guard bits so that 2R +/- D never
//            overflows for a divisor magnitude up to 2^(WIDTH-1).
// Revision : 1.0 - initial release
// ============================================================================
module div_step #(
  parameter int WIDTH = 32
) (
  input  wire logic [WIDTH+1:0] r_in,
  input  wire logic [WIDTH-1:0] q_in,
  input  wire logic [WIDTH-1:0] d_in,
  output logic      [WIDTH+1:0] r_out,
  output logic      [WIDTH-1:0] q_out
);

  logic [WIDTH+1:0] r_shift;
  logic [WIDTH+1:0] d_ext;

  // Shift {R,Q} left, then subtract D if R was non-negative, else add it back.
  always_comb begin
    r_shift = {r_in[WIDTH:0], q_in[WIDTH-1]};
    d_ext   = {2'b00, d_in};
    if (r_in[WIDTH+1]) begin
      r_out = r_shift + d_ext;
    end else begin
      r_out = r_shift - d_ext;
    end
    q_out = {q_in[WIDTH-2:0], ~r_out[WIDTH+1]};
  end

endmodule
`default_nettype wire

// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : mul_div_unit
// Brief    : Multi-cycle signed multiply (Booth) / divide (non-restoring).
//            Operands latched on start; 64-bit result returned as hi/lo.
//            MULDIV_RADIX4_EN: radix-4 Booth multiply, otherwise radix-2.
// Revision : 1.0 - initial release
// ============================================================================
module mul_div_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input wire logic      clk,
  input wire logic      clr,
  mul_div_unit_if.slave bus
);

  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(mul_iters(WIDTH) - 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(div_iters(WIDTH) - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH+1:0] acc_q, acc_d;      // Booth accumulator / division remainder
  logic [WIDTH-1:0] qreg_q, qreg_d;    // multiplier / dividend-quotient
  logic             qm1_q, qm1_d;      // Booth q-1 bit
  logic [WIDTH-1:0] mcand_q, mcand_d;  // multiplicand, |divisor| or raw dividend (DZ)
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;
  logic             div_zero_q, div_zero_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [WIDTH+1:0] m_ext;
  logic [WIDTH+1:0] booth_sum;
  logic [WIDTH+1:0] booth_acc;
  logic [WIDTH-1:0] booth_q;
  logic             booth_qm1;
  logic [WIDTH+1:0] div_r;
  logic [WIDTH-1:0] div_q;
  logic [WIDTH-1:0] rem_mag;
  logic [WIDTH-1:0] rem_fix;
  logic [WIDTH-1:0] quot_fix;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? (~x + 1'b1) : x;
  endfunction

  // State and datapath registers; reset clears everything, results included.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      qreg_q     <= '0;
      qm1_q      <= 1'b0;
      mcand_q    <= '0;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      qreg_q     <= qreg_d;
      qm1_q      <= qm1_d;
      mcand_q    <= mcand_d;
      sign_a_q   <= sign_a_d;
      sign_b_q   <= sign_b_d;
      div_zero_q <= div_zero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  // One Booth step: add the selected multiple of M, then arithmetic shift.
  always_comb begin
    m_ext = {{2{mcand_q[WIDTH-1]}}, mcand_q};
`ifdef MULDIV_RADIX4_EN
    case ({qreg_q[1:0], qm1_q})
      3'b001, 3'b010: booth_sum = acc_q + m_ext;
      3'b011:         booth_sum = acc_q + {m_ext[WIDTH:0], 1'b0};
      3'b100:         booth_sum = acc_q - {m_ext[WIDTH:0], 1'b0};
      3'b101, 3'b110: booth_sum = acc_q - m_ext;
      default:        booth_sum = acc_q;
    endcase
    booth_acc = {{2{booth_sum[WIDTH+1]}}, booth_sum[WIDTH+1:2]};
    booth_q   = {booth_sum[1:0], qreg_q[WIDTH-1:2]};
    booth_qm1 = qreg_q[1];
`else
    case ({qreg_q[0], qm1_q})
      2'b01:   booth_sum = acc_q + m_ext;
      2'b10:   booth_sum = acc_q - m_ext;
      default: booth_sum = acc_q;
    endcase
    booth_acc = {booth_sum[WIDTH+1], booth_sum[WIDTH+1:1]};
    booth_q   = {booth_sum[0], qreg_q[WIDTH-1:1]};
    booth_qm1 = qreg_q[0];
`endif
  end

  div_step #(
    .WIDTH (WIDTH)
  ) u_div_step (
    .r_in  (acc_q),
    .q_in  (qreg_q),
    .d_in  (mcand_q),
    .r_out (div_r),
    .q_out (div_q)
  );

  // Final division correction; modulo-2^WIDTH add is exact since 0 <= R < |B|.
  always_comb begin
    rem_mag  = acc_q[WIDTH+1] ? (acc_q[WIDTH-1:0] + mcand_q) : acc_q[WIDTH-1:0];
    rem_fix  = sign_a_q ? (~rem_mag + 1'b1) : rem_mag;
    quot_fix = (sign_a_q ^ sign_b_q) ? (~qreg_q + 1'b1) : qreg_q;
  end

  // Next-state and datapath control; DONE accepts a new start like IDLE.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    qreg_d     = qreg_q;
    qm1_d      = qm1_q;
    mcand_d    = mcand_q;
    sign_a_d   = sign_a_q;
    sign_b_d   = sign_b_q;
    div_zero_d = div_zero_q;
    hi_d       = hi_q;
    lo_d       = lo_q;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (bus.start) begin
          div_zero_d = 1'b0;
          sign_a_d   = bus.operand_a[WIDTH-1];
          sign_b_d   = bus.operand_b[WIDTH-1];
          acc_d      = '0;
          qm1_d      = 1'b0;
          if (bus.op == OP_MUL) begin
            mcand_d = bus.operand_a;
            qreg_d  = bus.operand_b;
            cnt_d   = MUL_LAST;
            state_d = MUL;
          end else if (bus.operand_b == '0) begin
            mcand_d = bus.operand_a;
            state_d = DZ;
          end else begin
            mcand_d = magnitude(bus.operand_b);
            qreg_d  = magnitude(bus.operand_a);
            cnt_d   = DIV_LAST;
            state_d = DIV;
          end
        end
      end
      MUL: begin
        acc_d  = booth_acc;
        qreg_d = booth_q;
        qm1_d  = booth_qm1;
        if (cnt_q == '0) begin
          hi_d    = booth_acc[WIDTH-1:0];
          lo_d    = booth_q;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DIV: begin
        acc_d  = div_r;
        qreg_d = div_q;
        if (cnt_q == '0) begin
          state_d = FIX;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      FIX: begin
        hi_d    = rem_fix;
        lo_d    = quot_fix;
        state_d = DONE;
      end
      DZ: begin
        div_zero_d = 1'b1;
        hi_d       = mcand_q;
        lo_d       = '1;
        state_d    = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decode directly from the state register.
  assign bus.busy     = (state_q == MUL) || (state_q == DIV) || (state_q == FIX) || (state_q == DZ);
  assign bus.done     = (state_q == DONE);
  assign bus.div_zero = div_zero_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_div_unit
// Brief    : Directed self-checking bench for mul_div_unit.
//            MULDIV_RADIX4_EN changes the expected MUL latency only.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mul_div_unit;

`ifdef MULDIV_RADIX4_EN
  localparam int MUL_LAT = 17;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 34;
  localparam int DZ_LAT  = 2;
  localparam int TIMEOUT = 80;

  logic clk;
  logic clr;
  int   n_cmp;
  int   n_err;

  mul_div_unit_if #(.WIDTH(32)) bus ();

  mul_div_unit #(
    .WIDTH (32)
  ) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Starts an operation at the current negedge (cycle 0) and waits for done.
  // inj > 0 pulses a conflicting start at that cycle while busy.
  task automatic run_op(input string tag, input logic opv, input logic [31:0] a,
                        input logic [31:0] b, input int exp_lat, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input logic exp_dz, input int inj);
    logic [31:0] hi0;
    logic [31:0] lo0;
    int          lat;
    bit          got;
    hi0 = bus.hi;
    lo0 = bus.lo;
    bus.start     = 1'b1;
    bus.op        = opv;
    bus.operand_a = a;
    bus.operand_b = b;
    lat = 0;
    got = 1'b0;
    for (int k = 1; k <= TIMEOUT && !got; k++) begin
      @(negedge clk);
      bus.start     = 1'b0;
      bus.operand_a = $urandom;
      bus.operand_b = $urandom;
      if (k == 1) begin
        check_eq({tag, " busy_c1"}, 64'(bus.busy), 64'd1);
        check_eq({tag, " dz_c1"}, 64'(bus.div_zero), 64'd0);
        check_eq({tag, " hi_hold"}, 64'(bus.hi), 64'(hi0));
        check_eq({tag, " lo_hold"}, 64'(bus.lo), 64'(lo0));
      end
      if (k == inj) begin
        bus.start = 1'b1;
        bus.op    = ~opv;
      end
      if (bus.done) begin
        got = 1'b1;
        lat = k;
      end
    end
    bus.start = 1'b0;
    check_eq({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check_eq({tag, " hi"}, 64'(bus.hi), 64'(exp_hi));
    check_eq({tag, " lo"}, 64'(bus.lo), 64'(exp_lo));
    check_eq({tag, " div_zero"}, 64'(bus.div_zero), 64'(exp_dz));
    check_eq({tag, " busy_done"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    clr           = 1'b0;
    bus.start     = 1'b0;
    bus.op        = 1'b0;
    bus.operand_a = '0;
    bus.operand_b = '0;

    repeat (3) @(negedge clk);
    check_eq("rst busy", 64'(bus.busy), 64'd0);
    check_eq("rst done", 64'(bus.done), 64'd0);
    check_eq("rst dz", 64'(bus.div_zero), 64'd0);
    check_eq("rst hi", 64'(bus.hi), 64'd0);
    check_eq("rst lo", 64'(bus.lo), 64'd0);
    clr = 1'b1;
    @(negedge clk);

    run_op("mul 7x-3", 1'b0, 32'h0000_0007, 32'hFFFF_FFFD, MUL_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 0);
    @(negedge clk);
    run_op("mul min^2", 1'b0, 32'h8000_0000, 32'h8000_0000, MUL_LAT, 32'h4000_0000, 32'h0000_0000, 1'b0, 0);
    @(negedge clk);
    run_op("mul max^2", 1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, MUL_LAT, 32'h3FFF_FFFF, 32'h0000_0001, 1'b0, 0);
    @(negedge clk);
    run_op("mul minx1", 1'b0, 32'h8000_0000, 32'h0000_0001, MUL_LAT, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 0);
    @(negedge clk);
    run_op("mul -1x-1", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT, 32'h0000_0000, 32'h0000_0001, 1'b0, 0);
    @(negedge clk);
    run_op("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'h0000_0002, DIV_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 0);
    @(negedge clk);
    run_op("div 100/7", 1'b1, 32'd100, 32'd7, DIV_LAT, 32'd2, 32'd14, 1'b0, 0);
    @(negedge clk);
    run_op("div 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, DIV_LAT, 32'd1, 32'hFFFF_FFFD, 1'b0, 0);
    @(negedge clk);
    run_op("div min/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, DIV_LAT, 32'd0, 32'h8000_0000, 1'b0, 0);
    @(negedge clk);
    run_op("div by 0", 1'b1, 32'h0000_1234, 32'd0, DZ_LAT, 32'h0000_1234, 32'hFFFF_FFFF, 1'b1, 0);
    @(negedge clk);
    run_op("mul after dz", 1'b0, 32'd5, 32'd6, MUL_LAT, 32'd0, 32'd30, 1'b0, 0);
    @(negedge clk);

    // A start while busy must neither disturb the result nor be queued.
    run_op("mul ign start", 1'b0, 32'h0001_0000, 32'h0001_0000, MUL_LAT, 32'd1, 32'd0, 1'b0, 10);
    @(negedge clk);
    check_eq("ign not queued busy", 64'(bus.busy), 64'd0);
    check_eq("ign not queued done", 64'(bus.done), 64'd0);

    // Back-to-back: second start issued in the done cycle of the first.
    run_op("b2b first", 1'b0, 32'h1234_5678, 32'h0000_0010, MUL_LAT, 32'd1, 32'h2345_6780, 1'b0, 0);
    run_op("b2b second", 1'b1, 32'd100, 32'd7, DIV_LAT, 32'd2, 32'd14, 1'b0, 0);
    @(negedge clk);

    // Asynchronous reset in the middle of a divide.
    bus.start     = 1'b1;
    bus.op        = 1'b1;
    bus.operand_a = 32'd1000;
    bus.operand_b = 32'd3;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    check_eq("pre-rst busy", 64'(bus.busy), 64'd1);
    clr = 1'b0;
    #1;
    check_eq("mid-rst busy", 64'(bus.busy), 64'd0);
    check_eq("mid-rst done", 64'(bus.done), 64'd0);
    check_eq("mid-rst dz", 64'(bus.div_zero), 64'd0);
    check_eq("mid-rst hi", 64'(bus.hi), 64'd0);
    check_eq("mid-rst lo", 64'(bus.lo), 64'd0);
    repeat (2) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    run_op("mul 3x4", 1'b0, 32'd3, 32'd4, MUL_LAT, 32'd0, 32'd12, 1'b0, 0);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
